// File: rtl/render_pkg.sv
`default_nettype none
// ============================================================================
// render_pkg: shared geometry defaults and types for the render pixel sequencer
// Revision: 1.0
// ============================================================================
package render_pkg;
  localparam int WIDTH_DEF  = 512;
  localparam int HEIGHT_DEF = 384;
  localparam int X_W        = 11;
  localparam int Y_W        = 10;

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2, DONE = 2'd3} seq_state_t;

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
  } coord_t;
endpackage
`default_nettype wire

// File: rtl/render_coord_fifo.sv
`default_nettype none
// ============================================================================
// render_coord_fifo: synchronous FIFO holding coordinates of in-flight requests
// Revision: 1.0
// ============================================================================
module render_coord_fifo
  import render_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  coord_t push_data,
  input  logic   pop,
  output coord_t pop_data,
  output logic   empty,
  output logic   full
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  coord_t        mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign pop_data = mem[rd_ptr[AW-1:0]];
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
endmodule
`default_nettype wire

// File: rtl/render_pixel_sequencer.sv
`default_nettype none
// ============================================================================
// render_pixel_sequencer: raster-order shader request issue and write-beat pairing
// Optional build macro: RENDER_INTERLACE_EN (alternate-field row scanning)
// Revision: 1.0
// ============================================================================
module render_pixel_sequencer
  import render_pkg::*;
#(
  parameter int WIDTH           = WIDTH_DEF,
  parameter int HEIGHT          = HEIGHT_DEF,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic           clk_in,
  input  logic           rst_in,
  input  logic           frame_start_in,
  output logic           busy_out,
  output logic           frame_done_out,
  output logic           req_valid_out,
  input  logic           req_ready_in,
  output logic [X_W-1:0] req_x_out,
  output logic [Y_W-1:0] req_y_out,
  input  logic           resp_valid_in,
  input  logic           resp_hit_in,
  input  logic [3:0]     resp_r_in,
  input  logic [3:0]     resp_g_in,
  input  logic [3:0]     resp_b_in,
  output logic [X_W-1:0] x_out_block,
  output logic [Y_W-1:0] y_out_block,
  output logic [3:0]     r_out,
  output logic [3:0]     g_out,
  output logic [3:0]     b_out,
  output logic           block_visible_out,
  output logic           valid_out,
  output logic           orphan_err_out,
  output logic           field_out
);
  localparam int             OW      = $clog2(MAX_OUTSTANDING) + 1;
  localparam logic [OW-1:0]  OUT_MAX = OW'(MAX_OUTSTANDING);
  localparam logic [OW-1:0]  OUT_ONE = OW'(1);
  localparam logic [X_W-1:0] X_LAST  = X_W'(WIDTH - 1);
  localparam logic [X_W-1:0] X_ONE   = X_W'(1);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_ISSUE = ISSUE;
  localparam logic [1:0] S_DRAIN = DRAIN;
  localparam logic [1:0] S_DONE  = DONE;

  logic [1:0]     state;
  logic [X_W-1:0] x_cnt;
  logic [Y_W-1:0] y_cnt;
  logic [OW-1:0]  outstanding;
  logic [Y_W-1:0] y_first;
  logic [Y_W-1:0] y_last;
  logic [Y_W-1:0] y_step;
  logic           fifo_empty;
  logic           fifo_full;
  coord_t         head;
  coord_t         push_coord;
  logic           issue;
  logic           resp_take;
  logic           last_coord;

`ifdef RENDER_INTERLACE_EN
  logic field;

  always_ff @(posedge clk_in) begin
    if (rst_in)                field <= 1'b0;
    else if (state == S_DONE)  field <= ~field;
  end

  assign y_first   = {{(Y_W-1){1'b0}}, field};
  assign y_last    = Y_W'(HEIGHT - 2) + y_first;
  assign y_step    = Y_W'(2);
  assign field_out = field;
`else
  assign y_first   = '0;
  assign y_last    = Y_W'(HEIGHT - 1);
  assign y_step    = Y_W'(1);
  assign field_out = 1'b0;
`endif

  // The FIFO occupancy mirrors outstanding, so both gates agree by construction.
  assign req_valid_out  = (state == S_ISSUE) && (outstanding < OUT_MAX) && !fifo_full;
  assign issue          = req_valid_out && req_ready_in;
  assign resp_take      = resp_valid_in && (outstanding != '0) && !fifo_empty;
  assign last_coord     = (x_cnt == X_LAST) && (y_cnt == y_last);
  assign req_x_out      = x_cnt;
  assign req_y_out      = y_cnt;
  assign busy_out       = (state != S_IDLE);
  assign frame_done_out = (state == S_DONE);
  assign push_coord     = '{x: x_cnt, y: y_cnt};

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state <= S_IDLE;
      x_cnt <= '0;
      y_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (frame_start_in) begin
            state <= S_ISSUE;
            x_cnt <= '0;
            y_cnt <= y_first;
          end
        end
        S_ISSUE: begin
          if (issue) begin
            if (x_cnt == X_LAST) begin
              x_cnt <= '0;
              y_cnt <= y_cnt + y_step;
            end else begin
              x_cnt <= x_cnt + X_ONE;
            end
            if (last_coord) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (outstanding == '0) state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in)                      outstanding <= '0;
    else if (issue && !resp_take)    outstanding <= outstanding + OUT_ONE;
    else if (!issue && resp_take)    outstanding <= outstanding - OUT_ONE;
  end

  // A stray response is flagged even if it coincides with a frame start.
  always_ff @(posedge clk_in) begin
    if (rst_in)                                         orphan_err_out <= 1'b0;
    else if (resp_valid_in && (outstanding == '0))      orphan_err_out <= 1'b1;
    else if ((state == S_IDLE) && frame_start_in)       orphan_err_out <= 1'b0;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      valid_out         <= 1'b0;
      x_out_block       <= '0;
      y_out_block       <= '0;
      r_out             <= '0;
      g_out             <= '0;
      b_out             <= '0;
      block_visible_out <= 1'b0;
    end else begin
      valid_out <= resp_take;
      if (resp_take) begin
        x_out_block       <= head.x;
        y_out_block       <= head.y;
        r_out             <= resp_r_in;
        g_out             <= resp_g_in;
        b_out             <= resp_b_in;
        block_visible_out <= resp_hit_in;
      end
    end
  end

  render_coord_fifo #(
    .DEPTH(MAX_OUTSTANDING)
  ) u_coord_fifo (
    .clk       (clk_in),
    .rst       (rst_in),
    .push      (issue),
    .push_data (push_coord),
    .pop       (resp_take),
    .pop_data  (head),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );
endmodule
`default_nettype wire

// File: tb/tb_render_pixel_sequencer.sv
`default_nettype none
// Bench for render_pixel_sequencer: raster-order reference model, random shader
// latency/backpressure, table-driven colour vectors and directed corner cases.
module tb_render_pixel_sequencer;
  import render_pkg::*;

  localparam int TW = 8;
  localparam int TH = 4;
  localparam int MO = 8;

  logic           clk_in = 1'b0;
  logic           rst_in, frame_start_in, req_ready_in, resp_valid_in, resp_hit_in;
  logic [3:0]     resp_r_in, resp_g_in, resp_b_in;
  logic           busy_out, frame_done_out, req_valid_out, valid_out;
  logic           block_visible_out, orphan_err_out, field_out;
  logic [X_W-1:0] req_x_out, x_out_block;
  logic [Y_W-1:0] req_y_out, y_out_block;
  logic [3:0]     r_out, g_out, b_out;

  always #5 clk_in = ~clk_in;

  render_pixel_sequencer #(.WIDTH(TW), .HEIGHT(TH), .MAX_OUTSTANDING(MO)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .frame_start_in(frame_start_in),
    .busy_out(busy_out), .frame_done_out(frame_done_out),
    .req_valid_out(req_valid_out), .req_ready_in(req_ready_in),
    .req_x_out(req_x_out), .req_y_out(req_y_out),
    .resp_valid_in(resp_valid_in), .resp_hit_in(resp_hit_in),
    .resp_r_in(resp_r_in), .resp_g_in(resp_g_in), .resp_b_in(resp_b_in),
    .x_out_block(x_out_block), .y_out_block(y_out_block),
    .r_out(r_out), .g_out(g_out), .b_out(b_out),
    .block_visible_out(block_visible_out), .valid_out(valid_out),
    .orphan_err_out(orphan_err_out), .field_out(field_out)
  );

  typedef struct {
    int x; int y;
    bit hit; bit [3:0] r; bit [3:0] g; bit [3:0] b;
    bit vis; bit [3:0] er; bit [3:0] eg; bit [3:0] eb;
    int due;
  } pend_t;

  typedef struct {
    bit hit; bit [3:0] r; bit [3:0] g; bit [3:0] b;
    bit vis; bit [3:0] er; bit [3:0] eg; bit [3:0] eb;
  } vec_t;

  vec_t  vecs [6];
  pend_t pend_q[$];
  int    issue_x[$];
  int    issue_y[$];
  pend_t exp_beat, last_beat;
  int    checks = 0, errors = 0, cyc = 0, hs_count = 0, beats_left = 0, tbl_idx = -1;
  bit    active = 0, exp_field = 0, exp_orphan = 0, exp_busy = 0, exp_done = 0;
  bit    done_due = 0, exp_valid = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected coordinate list for one frame, straight from the scan rules.
  task automatic plan_frame();
    int step, y0;
    issue_x.delete();
    issue_y.delete();
`ifdef RENDER_INTERLACE_EN
    step = 2;
    y0   = int'(exp_field);
`else
    step = 1;
    y0   = 0;
`endif
    for (int y = y0; y < TH; y += step)
      for (int x = 0; x < TW; x++) begin
        issue_x.push_back(x);
        issue_y.push_back(y);
      end
    beats_left = issue_x.size();
  endtask

  task automatic clear_model();
    pend_q.delete();
    issue_x.delete();
    issue_y.delete();
    active = 0; exp_field = 0; exp_orphan = 0; exp_busy = 0; exp_done = 0;
    done_due = 0; exp_valid = 0; beats_left = 0;
    last_beat = '{default: 0};
    exp_beat  = '{default: 0};
  endtask

  task automatic cycle(input bit start, input int ready_pct, input int resp_pct, input bit orphan);
    bit    exp_rv, hs, rsp;
    pend_t p;
    @(negedge clk_in);
    cyc++;
    chk("valid_out", valid_out, exp_valid);
    if (exp_valid) begin
      chk("x_out_block", x_out_block, exp_beat.x);
      chk("y_out_block", y_out_block, exp_beat.y);
      chk("r_out", r_out, exp_beat.er);
      chk("g_out", g_out, exp_beat.eg);
      chk("b_out", b_out, exp_beat.eb);
      chk("block_visible_out", block_visible_out, exp_beat.vis);
      last_beat = exp_beat;
      beats_left--;
      if (beats_left == 0) done_due = 1;
    end else begin
      chk("x_hold", x_out_block, last_beat.x);
      chk("r_hold", r_out, last_beat.er);
      chk("vis_hold", block_visible_out, last_beat.vis);
    end
    chk("frame_done_out", frame_done_out, exp_done);
    chk("busy_out", busy_out, exp_busy);
    chk("orphan_err_out", orphan_err_out, exp_orphan);
    chk("field_out", field_out, exp_field);
    exp_rv = active && (issue_x.size() > 0) && (pend_q.size() < MO);
    chk("req_valid_out", req_valid_out, exp_rv);
    if (exp_rv) begin
      chk("req_x_out", req_x_out, issue_x[0]);
      chk("req_y_out", req_y_out, issue_y[0]);
    end

    // Drive inputs for the coming rising edge.
    req_ready_in   = ($urandom_range(99) < ready_pct);
    frame_start_in = start;
    rsp = (pend_q.size() > 0) && (pend_q[0].due <= cyc) && ($urandom_range(99) < resp_pct);
    resp_valid_in = rsp || orphan;
    if (rsp) begin
      resp_hit_in = pend_q[0].hit;
      resp_r_in   = pend_q[0].r;
      resp_g_in   = pend_q[0].g;
      resp_b_in   = pend_q[0].b;
    end else begin
      resp_hit_in = 1'($urandom);
      resp_r_in   = 4'($urandom);
      resp_g_in   = 4'($urandom);
      resp_b_in   = 4'($urandom);
    end
    hs = exp_rv && req_ready_in;

    // Effects of that edge on the reference model.
    if (orphan && pend_q.size() == 0) exp_orphan = 1;
    exp_valid = rsp;
    if (rsp) exp_beat = pend_q.pop_front();
    if (hs) begin
      p.x = issue_x.pop_front();
      p.y = issue_y.pop_front();
      if (tbl_idx >= 0 && tbl_idx < 6) begin
        p.hit = vecs[tbl_idx].hit; p.r = vecs[tbl_idx].r; p.g = vecs[tbl_idx].g; p.b = vecs[tbl_idx].b;
        p.vis = vecs[tbl_idx].vis; p.er = vecs[tbl_idx].er; p.eg = vecs[tbl_idx].eg; p.eb = vecs[tbl_idx].eb;
        tbl_idx++;
      end else begin
        p.hit = 1'($urandom); p.r = 4'($urandom); p.g = 4'($urandom); p.b = 4'($urandom);
        p.vis = p.hit; p.er = p.r; p.eg = p.g; p.eb = p.b;
      end
      p.due = cyc + int'($urandom_range(1, 4));
      pend_q.push_back(p);
      hs_count++;
    end
    if (start && !active) begin
      active = 1; exp_busy = 1; exp_orphan = 0;
      plan_frame();
    end else if (exp_done) begin
      exp_done = 0; exp_busy = 0; active = 0;
`ifdef RENDER_INTERLACE_EN
      exp_field = ~exp_field;
`endif
    end else if (done_due) begin
      done_due = 0; exp_done = 1;
    end
  endtask

  task automatic run_to_done(input int rp, input int sp);
    int n = 0;
    while (active && n < 2000) begin
      cycle($urandom_range(99) < 3, rp, sp, 0);
      n++;
    end
    chk("frame_completes", active, 0);
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    rst_in = 1; frame_start_in = 0; req_ready_in = 0; resp_valid_in = 0;
    clear_model();
    @(negedge clk_in);
    chk("rst_busy", busy_out, 0);
    chk("rst_req_valid", req_valid_out, 0);
    chk("rst_frame_done", frame_done_out, 0);
    chk("rst_valid_out", valid_out, 0);
    rst_in = 0;
  endtask

  initial begin
    vecs[0] = '{hit: 0, r: 4'hF, g: 4'h0, b: 4'hA, vis: 0, er: 4'hF, eg: 4'h0, eb: 4'hA};
    vecs[1] = '{hit: 1, r: 4'hF, g: 4'h0, b: 4'hA, vis: 1, er: 4'hF, eg: 4'h0, eb: 4'hA};
    vecs[2] = '{hit: 1, r: 4'h0, g: 4'h0, b: 4'h0, vis: 1, er: 4'h0, eg: 4'h0, eb: 4'h0};
    vecs[3] = '{hit: 0, r: 4'hF, g: 4'hF, b: 4'hF, vis: 0, er: 4'hF, eg: 4'hF, eb: 4'hF};
    vecs[4] = '{hit: 1, r: 4'h5, g: 4'hA, b: 4'h3, vis: 1, er: 4'h5, eg: 4'hA, eb: 4'h3};
    vecs[5] = '{hit: 0, r: 4'h1, g: 4'h2, b: 4'h4, vis: 0, er: 4'h1, eg: 4'h2, eb: 4'h4};

    rst_in = 1; frame_start_in = 0; req_ready_in = 0; resp_valid_in = 0;
    resp_hit_in = 0; resp_r_in = 0; resp_g_in = 0; resp_b_in = 0;
    clear_model();
    repeat (2) @(negedge clk_in);
    rst_in = 0;

    // Reset state, then a stray response while idle.
    repeat (2) cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 1);
    repeat (3) cycle(0, 0, 0, 0);

    // Colour/visibility vectors on the first responses of a frame.
    tbl_idx = 0;
    cycle(1, 100, 100, 0);
    run_to_done(100, 100);
    tbl_idx = -1;

    // Random backpressure and response timing over several frames.
    for (int i = 0; i < 4; i++) begin
      cycle(1, 0, 0, 0);
      run_to_done(int'($urandom_range(30, 100)), int'($urandom_range(30, 100)));
      repeat (2) cycle(0, 0, 0, 0);
    end

    // Shader silent: issue stops at the outstanding limit; one response frees one slot.
    hs_count = 0;
    cycle(1, 100, 0, 0);
    repeat (20) cycle(0, 100, 0, 0);
    chk("hs_at_limit", hs_count, MO);
    chk("req_valid_stalled", req_valid_out, 0);
    cycle(0, 100, 100, 0);
    repeat (5) cycle(0, 100, 0, 0);
    chk("hs_after_one_resp", hs_count, MO + 1);

    // Abort mid-frame, then a clean frame must run from scratch.
    do_reset();
    repeat (3) cycle(0, 0, 0, 0);
    cycle(1, 0, 0, 0);
    run_to_done(70, 70);
    repeat (2) cycle(0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
